bcd_convert_arbiter: RTL

//  Shared sequential double-dabble BIN->BCD engine serving two requesters (X and Y mouse cell).

---
 rtl/bcd_convert_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bcd_convert_arbiter.sv
// Shared sequential double-dabble binary-to-BCD converter for two requesters.
// Round-robin arbitration, one operand bit per clock, last result held per channel.
module bcd_convert_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iReqX,
    input  logic [DATA_W-1:0]     iX_cell,
    output logic                  oAckX,
    output logic [4*DIGITS-1:0]   oBCDX,
    output logic                  oValidX,
    input  logic                  iReqY,
    input  logic [DATA_W-1:0]     iY_cell,
    output logic                  oAckY,
    output logic [4*DIGITS-1:0]   oBCDY,
    output logic                  oValidY,
    output logic                  oBusy
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic              grant_x, grant_y;
    logic              last_grant_q;  // 0 = X, 1 = Y
    logic              sel_q;
    logic [DATA_W-1:0] shift_q;
    logic [BcdW-1:0]   accum_q, accum_adj;
    logic [CntW-1:0]   count_q;
    logic              ack_x_q, ack_y_q, valid_x_q, valid_y_q;
    logic [BcdW-1:0]   bcd_x_q, bcd_y_q;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_x = 1'b0;
        grant_y = 1'b0;
        unique case (state_q)
            StIdle: begin
                // On a tie the channel that was not served last wins.
                if (iReqX && (!iReqY || last_grant_q)) begin
                    grant_x = 1'b1;
                end else if (iReqY) begin
                    grant_y = 1'b1;
                end
                if (grant_x || grant_y) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (count_q == CntW'(DATA_W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        accum_adj = accum_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (accum_q[4*d +: 4] > 4'd4) begin
                accum_adj[4*d +: 4] = accum_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            shift_q      <= '0;
            accum_q      <= '0;
            count_q      <= '0;
            ack_x_q      <= 1'b0;
            ack_y_q      <= 1'b0;
            valid_x_q    <= 1'b0;
            valid_y_q    <= 1'b0;
            bcd_x_q      <= '0;
            bcd_y_q      <= '0;
        end else begin
            ack_x_q   <= grant_x;
            ack_y_q   <= grant_y;
            valid_x_q <= 1'b0;
            valid_y_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_x || grant_y) begin
                        shift_q      <= grant_x ? iX_cell : iY_cell;
                        accum_q      <= '0;
                        count_q      <= '0;
                        sel_q        <= grant_y;
                        last_grant_q <= grant_y;
                    end
                end
                StShift: begin
                    {accum_q, shift_q} <= {accum_adj[BcdW-2:0], shift_q, 1'b0};
                    count_q            <= count_q + 1'b1;
                end
                StDone: begin
                    if (sel_q) begin
                        bcd_y_q   <= accum_q;
                        valid_y_q <= 1'b1;
                    end else begin
                        bcd_x_q   <= accum_q;
                        valid_x_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        oBusy   = (state_q != StIdle);
        oAckX   = ack_x_q;
        oAckY   = ack_y_q;
        oValidX = valid_x_q;
        oValidY = valid_y_q;
        oBCDX   = bcd_x_q;
        oBCDY   = bcd_y_q;
    end

endmodule
